// File: rtl/mbc_bus_arbiter.sv
// mbc_bus_arbiter
// Shares one cartridge ROM/flash between the Game Boy (MBC mapping side) and
// a host port. The Game Boy always wins: its request preempts any host access
// that has not yet reached the acknowledge cycle, and the host retries
// automatically once the Game Boy releases the bus. Host accesses use a
// setup / strobe / hold timing sequence driven by one shared phase counter.
// Every output comes straight from a flop so the memory strobes are glitch-free.

module mbc_bus_arbiter #(
    parameter int SETUP_CYC  = 1,   // address/data setup cycles before strobe (1..15)
    parameter int STROBE_CYC = 4,   // strobe-low cycles (1..15)
    parameter int HOLD_CYC   = 1    // strobe-high hold cycles (1..15)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gb_req,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [22:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    input  logic [7:0]  mem_rdata,
    output logic        gb_sel,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_dq_oe,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [7:0]  abort_cnt
);

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GB_OWN = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Phase counter reload values: a timed state of N cycles starts at N-1
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    localparam logic [7:0] ABORT_MAX = 8'hFF;

    // Synchronizer flops for the asynchronous Game Boy request
    logic        r_gb_req_meta;
    logic        r_gb_req_s;

    // FSM registers
    logic [2:0]  r_state;
    logic [3:0]  r_phase_cnt;
    logic        r_we;        // direction of the transaction in flight
    logic [7:0]  r_rd_cap;    // read data captured on the last strobe cycle

    // Next-state decode
    logic [2:0]  w_next_state;
    logic [3:0]  w_next_cnt;
    logic        w_start;     // IDLE -> SETUP, latch host inputs
    logic        w_abort;     // host transaction preempted by the Game Boy
    logic        w_capture;   // last STROBE cycle, sample mem_rdata
    logic        w_we_eff;    // direction valid for the next state
    logic        w_host_busy; // next state owns the bus for the host

    // Two-flop synchronizer; only r_gb_req_s is allowed into the FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gb_req_meta <= 1'b0;
            r_gb_req_s    <= 1'b0;
        end else begin
            r_gb_req_meta <= gb_req;
            r_gb_req_s    <= r_gb_req_meta;
        end
    end

    // Next-state, phase counter and event decode
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_phase_cnt;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_gb_req_s) begin
                    w_next_state = ST_GB_OWN;
                    w_next_cnt   = 4'd0;
                end else if (host_req) begin
                    w_next_state = ST_SETUP;
                    w_next_cnt   = SETUP_LD;
                    w_start      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end
            end
            ST_GB_OWN: begin
                // a waiting host must pass through IDLE before it may start
                if (r_gb_req_s) begin
                    w_next_state = ST_GB_OWN;
                end else begin
                    w_next_state = ST_IDLE;
                end
                w_next_cnt = 4'd0;
            end
            ST_SETUP: begin
                if (r_gb_req_s) begin
                    w_next_state = ST_GB_OWN;
                    w_next_cnt   = 4'd0;
                    w_abort      = 1'b1;
                end else if (r_phase_cnt == 4'd0) begin
                    w_next_state = ST_STROBE;
                    w_next_cnt   = STROBE_LD;
                end else begin
                    w_next_cnt   = r_phase_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_gb_req_s) begin
                    w_next_state = ST_GB_OWN;
                    w_next_cnt   = 4'd0;
                    w_abort      = 1'b1;
                end else if (r_phase_cnt == 4'd0) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = HOLD_LD;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt   = r_phase_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_gb_req_s) begin
                    w_next_state = ST_GB_OWN;
                    w_next_cnt   = 4'd0;
                    w_abort      = 1'b1;
                end else if (r_phase_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt   = r_phase_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                // the acknowledge cycle is never aborted; the Game Boy waits one more cycle
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Direction and bus-ownership view of the next state, used to register outputs
    always_comb begin
        w_we_eff    = w_start ? host_we : r_we;
        w_host_busy = (w_next_state == ST_SETUP) ||
                      (w_next_state == ST_STROBE) ||
                      (w_next_state == ST_HOLD);
    end

    // FSM state and phase counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase_cnt <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_phase_cnt <= w_next_cnt;
        end
    end

    // Bus mux select and memory strobes, registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gb_sel    <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_dq_oe <= 1'b0;
        end else begin
            gb_sel    <= (w_next_state == ST_IDLE) || (w_next_state == ST_GB_OWN);
            mem_oe_n  <= !((w_next_state == ST_STROBE) && !w_we_eff);
            mem_we_n  <= !((w_next_state == ST_STROBE) && w_we_eff);
            mem_dq_oe <= w_host_busy && w_we_eff;
        end
    end

    // Latch the host address, data and direction when a transaction starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= 23'd0;
            mem_wdata <= 8'd0;
            r_we      <= 1'b0;
        end else if (w_start) begin
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            r_we      <= host_we;
        end
    end

    // Read data capture on the final strobe cycle and hand-off to the host in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_cap   <= 8'd0;
            host_rdata <= 8'd0;
            host_ack   <= 1'b0;
        end else begin
            if (w_capture && !r_we) begin
                r_rd_cap <= mem_rdata;
            end
            if ((w_next_state == ST_DONE) && !r_we) begin
                host_rdata <= r_rd_cap;
            end
            host_ack <= (w_next_state == ST_DONE);
        end
    end

    // Saturating count of host transactions preempted by the Game Boy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abort_cnt <= 8'd0;
        end else if (w_abort && (abort_cnt != ABORT_MAX)) begin
            abort_cnt <= abort_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mbc_bus_arbiter.sv
// Self-checking bench for mbc_bus_arbiter: directed scenarios plus randomized
// host transactions with random Game Boy preemptions, checked against a
// transaction-level timing model of the arbiter.

module tb_mbc_bus_arbiter;

    localparam int S = 1;
    localparam int T = 4;
    localparam int H = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gb_req;
    logic        host_req;
    logic        host_we;
    logic [22:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [7:0]  mem_rdata;
    logic        gb_sel;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_dq_oe;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [7:0]  abort_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_abort = 0;
    logic [7:0]  exp_rdata = 8'd0;

    always #5 clk = ~clk;

    mbc_bus_arbiter #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
        .clk(clk), .rst_n(rst_n), .gb_req(gb_req), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .mem_rdata(mem_rdata),
        .gb_sel(gb_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dq_oe(mem_dq_oe), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .abort_cnt(abort_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_abort(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_gb_sel"},  32'(gb_sel), 32'd1);
        chk({tag, "_oe_n"},    32'(mem_oe_n), 32'd1);
        chk({tag, "_we_n"},    32'(mem_we_n), 32'd1);
        chk({tag, "_dq_oe"},   32'(mem_dq_oe), 32'd0);
        chk({tag, "_ack"},     32'(host_ack), 32'd0);
        chk({tag, "_addr"},    32'(mem_addr), 32'd0);
        chk({tag, "_wdata"},   32'(mem_wdata), 32'd0);
        chk({tag, "_rdata"},   32'(host_rdata), 32'd0);
        chk({tag, "_abort"},   32'(abort_cnt), 32'd0);
    endtask

    task automatic start_host(input logic we, input logic [22:0] addr, input logic [7:0] wd);
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        host_req   = 1'b1;
    endtask

    // Follow one host transaction to its acknowledge. pre_k > 0 raises gb_req
    // after the pre_k-th strobe-low cycle of the first attempt.
    task automatic monitor(input string tag, input int pre_k, input bit rand_rd, input int exp_entry);
        int         tk = 0;
        int         entry = -1;
        int         first_entry = -1;
        int         oe_lo = 0;
        int         we_lo = 0;
        int         dq = 0;
        int         strobes = 0;
        int         viol = 0;
        int         r = -1;
        int         extra_ack = 0;
        bit         abort_pred = 1'b0;
        bit         done = 1'b0;
        logic [7:0] last_rd = 8'd0;
        logic       we;
        logic [22:0] addr;
        logic [7:0] wd;
        we   = host_we;
        addr = host_addr;
        wd   = host_wdata;
        while (!done && tk < 80) begin
            tick;
            tk++;
            if ((!mem_oe_n && !mem_we_n) || (gb_sel && (!mem_oe_n || !mem_we_n))) viol++;
            if (r >= 0 && tk == r + 3 && abort_pred) begin
                chk({tag, "_pre_gb_sel"}, 32'(gb_sel), 32'd1);
                chk({tag, "_pre_bus"}, 32'({mem_oe_n, mem_we_n, mem_dq_oe}), 32'b110);
                entry = -1; oe_lo = 0; we_lo = 0; dq = 0;
            end
            if (r >= 0 && tk == r + 5) gb_req = 1'b0;
            if (!gb_sel && entry < 0) begin
                entry = tk;
                if (first_entry < 0) first_entry = tk;
            end
            if (!mem_oe_n) oe_lo++;
            if (!mem_we_n) we_lo++;
            if (mem_dq_oe) dq++;
            if (!mem_oe_n || !mem_we_n) begin
                strobes++;
                if (pre_k > 0 && r < 0 && strobes == pre_k) begin
                    gb_req     = 1'b1;
                    r          = tk;
                    abort_pred = (pre_k <= T + H - 2);
                end
            end
            if (host_ack) begin
                done     = 1'b1;
                host_req = 1'b0;
            end
            mem_rdata = rand_rd ? 8'($urandom) : 8'hA5;
            if (!mem_oe_n) last_rd = mem_rdata;
        end
        gb_req = 1'b0;
        if (abort_pred) exp_abort++;
        if (!we) exp_rdata = last_rd;
        chk({tag, "_ack_seen"}, 32'(done), 32'd1);
        chk({tag, "_entry"}, first_entry, exp_entry);
        chk({tag, "_duration"}, tk - entry, S + T + H);
        chk({tag, "_oe_cycles"}, oe_lo, we ? 0 : T);
        chk({tag, "_we_cycles"}, we_lo, we ? T : 0);
        chk({tag, "_dq_cycles"}, dq, we ? S + T + H : 0);
        chk({tag, "_rdata"}, 32'(host_rdata), 32'(exp_rdata));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
        chk({tag, "_abort"}, 32'(abort_cnt), sat_abort(exp_abort));
        for (int i = 0; i < 6; i++) begin
            tick;
            if (host_ack) extra_ack++;
            if ((!mem_oe_n && !mem_we_n) || (gb_sel && (!mem_oe_n || !mem_we_n))) viol++;
        end
        chk({tag, "_extra_ack"}, extra_ack, 0);
        chk({tag, "_rdata_held"}, 32'(host_rdata), 32'(exp_rdata));
        chk({tag, "_strobe_safety"}, viol, 0);
        chk({tag, "_idle_gb_sel"}, 32'(gb_sel), 32'd1);
    endtask

    initial begin
        int zero_sel;
        int wait_n;
        int acks;
        rst_n      = 1'b0;
        gb_req     = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 23'd0;
        host_wdata = 8'd0;
        mem_rdata  = 8'd0;
        tick; tick; tick;
        check_reset("reset");
        rst_n = 1'b1;
        tick;

        // directed read
        start_host(1'b0, 23'h012345, 8'h00);
        monitor("rd_a5", 0, 1'b0, 1);
        chk("rd_a5_value", 32'(host_rdata), 32'h0000_00A5);

        // directed write to top address
        start_host(1'b1, 23'h7FFFFF, 8'h3C);
        monitor("wr_top", 0, 1'b1, 1);

        // preemption in the second strobe cycle, then automatic retry
        start_host(1'b0, 23'h00ABCD, 8'h00);
        monitor("preempt2", 2, 1'b1, 1);

        // randomized transactions with occasional preemption
        for (int i = 0; i < 14; i++) begin
            logic [22:0] a;
            int          k;
            a = (i == 0) ? 23'd0 : ((i == 1) ? 23'h7FFFFF : 23'($urandom));
            k = (i % 3 == 2) ? int'($urandom_range(1, T)) : 0;
            start_host(1'($urandom_range(0, 1)), a, 8'($urandom));
            monitor("rand", k, 1'b1, 1);
        end

        // Game Boy and host request in the same IDLE cycle
        gb_req = 1'b1;
        tick; tick;
        start_host(1'b0, 23'h055AA5, 8'h00);
        zero_sel = 0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (!gb_sel) zero_sel++;
            if (host_ack) acks++;
        end
        chk("same_cycle_gb_priority", zero_sel, 0);
        chk("same_cycle_no_ack", acks, 0);
        gb_req = 1'b0;
        monitor("same_cycle", 0, 1'b1, 4);

        // 300 forced preemptions, abort counter saturates
        start_host(1'b0, 23'h1F0F0F, 8'h00);
        for (int i = 0; i < 300; i++) begin
            wait_n = 0;
            while (gb_sel && wait_n < 20) begin tick; wait_n++; end
            if (gb_sel) begin chk("sat_setup_timeout", 32'(gb_sel), 32'd0); break; end
            gb_req = 1'b1;
            wait_n = 0;
            while (!gb_sel && wait_n < 10) begin tick; wait_n++; end
            chk("sat_latency", wait_n, 3);
            gb_req = 1'b0;
            exp_abort++;
            if (i == 9) chk("sat_abort_10", 32'(abort_cnt), sat_abort(exp_abort));
        end
        chk("sat_abort_255", 32'(abort_cnt), 32'd255);
        monitor("sat_final", 0, 1'b1, 4);

        // reset asserted during HOLD of a write
        start_host(1'b1, 23'h2468AC, 8'h5A);
        for (int i = 0; i < S + T + 1; i++) tick;
        chk("hold_reached", 32'({gb_sel, mem_oe_n, mem_we_n, mem_dq_oe}), 32'b0111);
        rst_n = 1'b0;
        tick;
        check_reset("rst_hold");
        rst_n    = 1'b1;
        host_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (host_ack) acks++;
        end
        chk("rst_hold_no_ack", acks, 0);
        chk("rst_hold_abort", 32'(abort_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mbc_bus_arbiter.md
MBC_BUS_ARBITER -- requirements
Module: mbc_bus_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SETUP_CYC, 1: host address/data setup cycles before strobe (1..15)
- STROBE_CYC, 4: host strobe-low cycles (1..15)
- HOLD_CYC, 1: strobe-high hold cycles after strobe (1..15)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock
- rst_n, in, 1: reset, synchronous, active-low
- gb_req, in, 1: Game Boy cartridge access active (asynchronous level)
- host_req, in, 1: host transaction request (level)
- host_we, in, 1: 1 = write, 0 = read
- host_addr, in, 23: host flat ROM/flash byte address
- host_wdata, in, 8: host write data
- host_ack, out, 1: one-cycle transaction-complete pulse
- host_rdata, out, 8: read data, valid while host_ack=1 and held until the next ack
- mem_rdata, in, 8: memory data bus input
- gb_sel, out, 1: 1 = memory mux routed to the Game Boy/MBC mapping, 0 = host
- mem_addr, out, 23: host-side memory address
- mem_wdata, out, 8: host-side write data
- mem_dq_oe, out, 1: host drives the memory data bus
- mem_oe_n, out, 1: host read strobe
- mem_we_n, out, 1: host write strobe
- abort_cnt, out, 8: saturating count of preempted host transactions

REQ-003 Clock and reset SHALL be one clock, clk; reset SHALL be rst_n, synchronous and active-low.

Function
REQ-004 gb_req SHALL pass through a 2-flop synchronizer; gb_req_s is its output. The FSM SHALL use only gb_req_s.
REQ-005 The FSM SHALL have the states IDLE, GB_OWN, SETUP, STROBE, HOLD and DONE. All outputs SHALL be registered.
REQ-006 gb_sel SHALL be 1 in IDLE and GB_OWN and 0 in SETUP, STROBE, HOLD and DONE.
REQ-007 IDLE transitions:
- gb_req_s=1 -> GB_OWN (the Game Boy has priority over a simultaneous host_req).
- else host_req=1 -> SETUP.
- else remain in IDLE.
REQ-008 GB_OWN SHALL remain while gb_req_s=1, then go to IDLE. A pending host_req SHALL NOT enter SETUP until the first IDLE cycle.
REQ-009 On entry to SETUP, host_addr, host_we and host_wdata SHALL be latched into mem_addr and mem_wdata. mem_dq_oe SHALL equal host_we from SETUP through HOLD. SETUP SHALL last SETUP_CYC cycles.
REQ-010 In STROBE, mem_oe_n=0 (read) or mem_we_n=0 (write) SHALL be asserted for exactly STROBE_CYC cycles. For reads, mem_rdata SHALL be captured on the last STROBE cycle.
REQ-011 HOLD SHALL keep both strobes at 1 for HOLD_CYC cycles, then go to DONE.
REQ-012 DONE SHALL last 1 cycle, with host_ack=1 and host_rdata updated for reads (unchanged for writes), then go to IDLE.
REQ-013 The host SHALL keep its inputs stable from host_req rise until host_ack. A host_req still high in the IDLE cycle after DONE SHALL start a new transaction.
REQ-014 One shared 4-bit phase counter SHALL be loaded with N-1 on entry to each timed state. The state SHALL advance when the counter reaches 0. No wrap-around SHALL occur.
REQ-015 Preemption: gb_req_s=1 in SETUP, STROBE or HOLD SHALL, on the next cycle:
- force mem_oe_n=1, mem_we_n=1, mem_dq_oe=0 and gb_sel=1;
- enter GB_OWN;
- increment abort_cnt (saturating at 255);
- not assert host_ack.
After GB_OWN, the aborted transaction SHALL restart from SETUP if host_req=1.
REQ-016 gb_req_s in DONE SHALL NOT abort: ack completes, then IDLE -> GB_OWN.
REQ-017 Worst-case gb_req rise to gb_sel=1 SHALL be 3 clk cycles (2 synchronizer + 1 FSM).
REQ-018 mem_oe_n and mem_we_n SHALL never be 0 simultaneously, and neither SHALL be 0 while gb_sel=1.

Reset
REQ-019 While rst_n=0 at a clk edge, the next state SHALL be:
- FSM = IDLE; synchronizer flops = 0
- gb_sel=1, mem_oe_n=1, mem_we_n=1, mem_dq_oe=0, host_ack=0
- mem_addr=0, mem_wdata=0, host_rdata=0, abort_cnt=0
REQ-020 Reset mid-transaction SHALL abort without host_ack and SHALL NOT increment abort_cnt.

Verification
REQ-021 Host read, defaults, addr 0x012345, mem_rdata=0xA5: gb_sel falls in SETUP; mem_oe_n low for exactly 4 cycles; host_ack one cycle; host_rdata=0xA5; total 7 cycles from SETUP entry to DONE.
REQ-022 Host write 0x3C to 0x7FFFFF: mem_dq_oe=1 for SETUP..HOLD; mem_we_n low 4 cycles; mem_oe_n stays 1; host_ack once.
REQ-023 gb_req rises during the 2nd STROBE cycle: strobes high and gb_sel=1 within 3 cycles; abort_cnt 0->1; no ack. After gb_req falls, the transaction restarts from SETUP and acks once.
REQ-024 gb_req_s and host_req rise in the same IDLE cycle: GB_OWN is taken; the host starts only after gb_req_s=0.
REQ-025 300 forced preemptions: abort_cnt saturates at 255.
REQ-026 rst_n=0 asserted in HOLD: all REQ-019 values hold next cycle; no host_ack is asserted.
